systemizer_host: RTL
====================

// Module: systemizer_host
// PURPOSE
// Host-side initiator for the systemizer memory/control interface. Streams a matrix
// (N*M-bit words) into systemizer memory, pulses start, waits for completion, then
// streams the systemized matrix back out under backpressure. On systemizer fail or
// timeout the job ends without unload. Sits between top-level I/O/DMA and the systemizer.
// PARAMETERS
// N        20   matrix columns per memory word
// M        1    bits per GF(2^M) element
// L        200  matrix rows
// K        400  matrix columns
// RD_LAT   1    systemizer read latency in cycles (1..2)
// TIMEOUT  0    max cycles in WAIT; 0 = disabled
// PORTS
// clk              in   1    clock
// rst              in   1    synchronous, active-high reset
// cmd_go           in   1    start job; honoured only in IDLE
// in_valid         in   1    input word valid
// in_ready         out  1    input word accepted when in_valid&in_ready
// in_data          in   N*M  input matrix word
// out_valid        out  1    output word valid
// out_ready        in   1    downstream accepts output word
// out_data         out  N*M  systemized matrix word
// out_last         out  1    final word of job (addr WORDS-1)
// job_done         out  1    one-cycle pulse at end of every job
// job_status       out  2    00 ok, 01 fail, 10 timeout; valid at job_done, held to next cmd_go
// busy             out  1    state != IDLE
// sys_start        out  1    systemizer start pulse
// sys_start_right  out  1    constant 0
// sys_success      in   1    systemizer success pulse
// sys_fail         in   1    systemizer fail
// sys_wr_en        out  1    systemizer write strobe
// sys_wr_addr      out  AW   write address
// sys_wr_data      out  N*M  write data
// sys_rd_en        out  1    systemizer read strobe
// sys_rd_addr      out  AW   read address
// sys_rd_data      in   N*M  read data, valid RD_LAT cycles after sys_rd_en
// BEHAVIOUR
// - WORDS = L*K/N, AW = CLOG2(WORDS); addresses 0..WORDS-1 linear, never wrap.
// - Reset: state IDLE; every output 0; job_status 00; counters, credits, FIFO cleared.
// - FSM IDLE -> LOAD -> KICK -> WAIT -> UNLOAD -> FIN -> IDLE.
// - IDLE: in_ready=0; cmd_go -> LOAD, job_status<=00. cmd_go in any other state ignored.
// - LOAD: in_ready=1; word accepted at cycle t written at t+1 (sys_wr_en=1,
//   sys_wr_addr=wcnt). Accept of word WORDS-1 -> KICK; in_ready drops that edge.
// - KICK: sys_start=1 for exactly one cycle, the cycle after the last write -> WAIT.
// - WAIT: sys_fail -> FIN status 01 (fail wins if same cycle as success);
//   sys_success -> UNLOAD; wait counter reaching TIMEOUT -> FIN status 10.
// - UNLOAD: sys_rd_en only when fifo_count + inflight < DEPTH (DEPTH = RD_LAT+2);
//   rcnt increments per read; no read data ever dropped. out_last with word WORDS-1;
//   its handshake -> FIN. Sustained 1 word/cycle while out_ready=1.
// - out_valid held until handshake; out_data/out_last stable while stalled.
// - FIN: job_done=1 one cycle -> IDLE; busy low the following cycle.
// - sys_success/sys_fail outside WAIT ignored. in_valid outside LOAD not consumed.
// - rst mid-job: IDLE next cycle, FIFO flushed, in-flight read data discarded,
//   no job_done, strobes low.
// STRUCTURE
// - systemizer_pkg: state encoding, job_status codes, WORDS/AW localparam helpers.
// - Sub-module systemizer_host_fifo: DEPTH-entry synchronous FIFO (count output,
//   flush on rst) absorbing read latency for backpressure.
// - Top holds FSM, wcnt/rcnt address counters, credit counter, timeout counter.
// TESTING (L=4, K=8, N=4, M=1 -> WORDS=8)
// - Load words 0x1..0x8 back-to-back, sys_success 5 cycles after sys_start ->
//   writes addr 0..7 in order, single sys_start one cycle after addr 7, 8 outputs
//   equal model read data, out_last on 8th, job_done with status 00.
// - sys_fail in WAIT -> no sys_rd_en, job_done status 01, busy low next cycle.
// - TIMEOUT=16, no completion -> job_done exactly 16 WAIT cycles later, status 10.
// - Random out_ready (50%) during UNLOAD, RD_LAT=2 -> all 8 words, in order,
//   no loss/duplication, out_data stable while stalled.
// - rst asserted in UNLOAD after 3 outputs -> all outputs 0 next cycle, no job_done;
//   fresh job afterwards completes normally.
// - cmd_go pulsed during LOAD and WAIT, sys_success simultaneous with sys_fail -> ignored;
//   status 01.

Source files
------------

// File: rtl/systemizer_pkg.sv
// Shared definitions for the systemizer host: FSM encoding, job status codes
// and helpers that derive memory geometry from the matrix dimensions.
package systemizer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_KICK   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_UNLOAD = 3'd4,
        ST_FIN    = 3'd5
    } state_t;

    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_FAIL    = 2'b01;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

    // Number of memory words holding an L x K matrix packed N columns per word.
    function automatic int calc_words(input int l, input int k, input int n);
        return (l * k) / n;
    endfunction

    // Address width for a given word count (at least one bit).
    function automatic int calc_aw(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/systemizer_host_fifo.sv
// Small show-ahead FIFO that absorbs systemizer read latency so the unload
// path can stall on out_ready without dropping words already requested.
module systemizer_host_fifo
    import systemizer_pkg::*;
#(
    parameter  int DW    = 8,
    parameter  int DEPTH = 3,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          valid,
    output logic [CW-1:0] count
);

    logic [DW-1:0] mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_pop;

    // Upstream credit logic guarantees push never hits a full FIFO.
    assign do_pop = pop && (count_reg != '0);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Per-entry storage; entries are cleared so the head reads zero after reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (srst) begin
                    mem_reg[gi] <= '0;
                end else if (push && (wr_ptr_reg == PW'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            count_reg <= count_reg + CW'(push) - CW'(do_pop);
        end
    end

    assign pop_data = mem_reg[rd_ptr_reg];
    assign valid    = (count_reg != '0);
    assign count    = count_reg;

endmodule

// File: rtl/systemizer_host.sv
// Host-side initiator: loads a matrix into systemizer memory, kicks the
// systemizer, waits for completion and unloads the result under backpressure.
module systemizer_host
    import systemizer_pkg::*;
#(
    parameter  int N       = 20,
    parameter  int M       = 1,
    parameter  int L       = 200,
    parameter  int K       = 400,
    parameter  int RD_LAT  = 1,
    parameter  int TIMEOUT = 0,
    localparam int DW      = N * M,
    localparam int WORDS   = calc_words(L, K, N),
    localparam int AW      = calc_aw(WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_go,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          job_done,
    output logic [1:0]    job_status,
    output logic          busy,
    output logic          sys_start,
    output logic          sys_start_right,
    input  logic          sys_success,
    input  logic          sys_fail,
    output logic          sys_wr_en,
    output logic [AW-1:0] sys_wr_addr,
    output logic [DW-1:0] sys_wr_data,
    output logic          sys_rd_en,
    output logic [AW-1:0] sys_rd_addr,
    input  logic [DW-1:0] sys_rd_data
);

    localparam int DEPTH = RD_LAT + 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int RW    = $clog2(WORDS + 1);
    localparam int TW    = $clog2(TIMEOUT + 2);

    state_t            state_reg, state_next;
    logic [AW-1:0]     wcnt_reg;
    logic              wr_en_reg;
    logic [AW-1:0]     wr_addr_reg;
    logic [DW-1:0]     wr_data_reg;
    logic [RW-1:0]     rcnt_reg;
    logic [RD_LAT-1:0] vld_pipe_reg;
    logic [RD_LAT-1:0] last_pipe_reg;
    logic [TW-1:0]     wait_cnt_reg;
    logic [1:0]        status_reg;

    logic              go_accept;
    logic              in_accept;
    logic              last_accept;
    logic              timeout_hit;
    logic              out_fire;
    logic              rd_go;
    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     inflight;
    logic [CW:0]       credit_used;
    logic              fifo_valid;
    logic [DW:0]       fifo_head;

    assign go_accept   = (state_reg == ST_IDLE) && cmd_go;
    assign in_accept   = (state_reg == ST_LOAD) && in_valid;
    assign last_accept = in_accept && (wcnt_reg == AW'(WORDS - 1));
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_reg == TW'(TIMEOUT - 1));
    assign out_fire    = fifo_valid && out_ready;

    // Reads issued but not yet landed in the FIFO.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CW'(vld_pipe_reg[i]);
        end
    end

    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic; fail has priority over success in WAIT.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (cmd_go) state_next = ST_LOAD;
            ST_LOAD:   if (last_accept) state_next = ST_KICK;
            ST_KICK:   if (!wr_en_reg) state_next = ST_WAIT;
            ST_WAIT: begin
                if (sys_fail)         state_next = ST_FIN;
                else if (sys_success) state_next = ST_UNLOAD;
                else if (timeout_hit) state_next = ST_FIN;
            end
            ST_UNLOAD: if (out_fire && fifo_head[DW]) state_next = ST_FIN;
            ST_FIN:    state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // FSM outputs; the start pulse waits until the final write has retired.
    always_comb begin
        in_ready  = (state_reg == ST_LOAD);
        sys_start = (state_reg == ST_KICK) && !wr_en_reg;
        job_done  = (state_reg == ST_FIN);
        busy      = (state_reg != ST_IDLE);
        rd_go     = (state_reg == ST_UNLOAD) && (rcnt_reg < RW'(WORDS)) &&
                    (credit_used < (CW + 1)'(DEPTH));
    end

    // Load path: an accepted word is written one cycle later at address wcnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_reg    <= '0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            wr_en_reg <= in_accept;
            if (in_accept) begin
                wr_addr_reg <= wcnt_reg;
                wr_data_reg <= in_data;
            end
            if (go_accept) begin
                wcnt_reg <= '0;
            end else if (in_accept) begin
                wcnt_reg <= wcnt_reg + AW'(1);
            end
        end
    end

    // Read address counter, advanced once per issued read.
    always_ff @(posedge clk) begin
        if (rst || go_accept) begin
            rcnt_reg <= '0;
        end else if (rd_go) begin
            rcnt_reg <= rcnt_reg + RW'(1);
        end
    end

    // Read-latency tracking pipeline: valid flag and last-word tag per stage.
    generate
        for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_rd_pipe
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_pipe_reg[gi]  <= 1'b0;
                    last_pipe_reg[gi] <= 1'b0;
                end else if (gi == 0) begin
                    vld_pipe_reg[gi]  <= rd_go;
                    last_pipe_reg[gi] <= rd_go && (rcnt_reg == RW'(WORDS - 1));
                end else begin
                    vld_pipe_reg[gi]  <= vld_pipe_reg[(gi == 0) ? 0 : gi - 1];
                    last_pipe_reg[gi] <= last_pipe_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    // Cycles spent in WAIT; restarts whenever WAIT is left.
    always_ff @(posedge clk) begin
        if (rst || (state_reg != ST_WAIT)) begin
            wait_cnt_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_reg + TW'(1);
        end
    end

    // Job status: cleared on a new job, set on fail or timeout, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_reg <= STATUS_OK;
        end else if (go_accept) begin
            status_reg <= STATUS_OK;
        end else if (state_reg == ST_WAIT) begin
            if (sys_fail) begin
                status_reg <= STATUS_FAIL;
            end else if (!sys_success && timeout_hit) begin
                status_reg <= STATUS_TIMEOUT;
            end
        end
    end

    systemizer_host_fifo #(
        .DW    (DW + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .srst      (rst),
        .push      (vld_pipe_reg[RD_LAT-1]),
        .push_data ({last_pipe_reg[RD_LAT-1], sys_rd_data}),
        .pop       (out_fire),
        .pop_data  (fifo_head),
        .valid     (fifo_valid),
        .count     (fifo_count)
    );

    assign out_valid       = fifo_valid;
    assign out_data        = fifo_head[DW-1:0];
    assign out_last        = fifo_head[DW];
    assign job_status      = status_reg;
    assign sys_start_right = 1'b0;
    assign sys_wr_en       = wr_en_reg;
    assign sys_wr_addr     = wr_addr_reg;
    assign sys_wr_data     = wr_data_reg;
    assign sys_rd_en       = rd_go;
    assign sys_rd_addr     = rcnt_reg[AW-1:0];

endmodule
